// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: the instruction-fetch (im)
// read port and the data (dm) read/write port.
// master = the CPU side that issues requests; slave = the arbiter.
interface sram_port_arbiter_if;
  // Instruction-fetch port (read only)
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  // Data port (read when dm_we == 0, byte-masked write otherwise)
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output im_req, im_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  im_gnt, im_rvalid, im_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  im_req, im_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output im_gnt, im_rvalid, im_rdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between the instruction-fetch
// and data ports, one access per cycle. Grants are combinational; read data
// returns one cycle after the grant, matching the SRAM's 1-cycle read latency.
//
// Default build: the data port has fixed priority, and a starvation counter
// force-grants instruction fetch after MAX_WAIT consecutive denied cycles.
// Define SRAM_ARB_RR_EN to replace this with round-robin between the two
// ports (a last_winner flop; the starvation counter is removed).
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 14,  // SRAM word-address width
  parameter int unsigned MAX_WAIT = 4,   // denied im cycles before a forced grant
  parameter int unsigned CNT_W    = 4    // starvation counter width
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active low
  sram_port_arbiter_if.slave bus,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_a,
  output logic [3:0]        sram_web,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do
);

  // Who owns the SRAM read data arriving next cycle; writes own nothing.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IM    = 2'd1,
    OWN_DM_RD = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             im_gnt, dm_gnt;
  logic             dm_is_read;

  assign dm_is_read = (bus.dm_we == 4'h0);

`ifdef SRAM_ARB_RR_EN
  typedef enum logic {
    WIN_DM = 1'b0,
    WIN_IM = 1'b1
  } winner_e;

  winner_e last_winner_q, last_winner_d;

  // Round-robin has no starvation counter.
  assign wait_cnt_q = '0;

  // Grant: on a simultaneous request the port that did not win last time wins.
  always_comb begin
    im_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (bus.im_req && bus.dm_req) begin
      if (last_winner_q == WIN_IM) dm_gnt = 1'b1;
      else                         im_gnt = 1'b1;
    end else begin
      im_gnt = bus.im_req;
      dm_gnt = bus.dm_req;
    end
  end

  // Remember the most recent winner; hold it across idle cycles.
  always_comb begin
    last_winner_d = last_winner_q;
    if (im_gnt)      last_winner_d = WIN_IM;
    else if (dm_gnt) last_winner_d = WIN_DM;
  end

  // Round-robin state register; IM after reset so dm wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_winner_q <= WIN_IM;
    else      last_winner_q <= last_winner_d;
  end

  logic unused_rr;
  assign unused_rr = ^wait_cnt_q;
`else
  logic [CNT_W-1:0] wait_cnt_d;
  logic             force_im;

  assign force_im = bus.im_req && (wait_cnt_q == CNT_W'(MAX_WAIT));

  // Grant: forced im first, then fixed dm priority, then im.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can leave it unassigned and infer a latch.
    im_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (force_im)         im_gnt = 1'b1;
    else if (bus.dm_req)  dm_gnt = 1'b1;
    else if (bus.im_req)  im_gnt = 1'b1;
  end

  // Starvation counter: count denied im cycles, saturate at MAX_WAIT,
  // clear on an im grant or when im stops requesting.
  always_comb begin
    wait_cnt_d = '0;
    if (bus.im_req && !im_gnt) begin
      if (wait_cnt_q == CNT_W'(MAX_WAIT)) wait_cnt_d = wait_cnt_q;
      else                                wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values regardless of block evaluation order.
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign bus.im_gnt = im_gnt;
  assign bus.dm_gnt = dm_gnt;

  // SRAM drive: steer the winning port onto the SRAM pins; idle pins are quiet.
  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_a   = '0;
    sram_web = 4'hF;
    sram_di  = '0;
    if (im_gnt) begin
      sram_cs = 1'b1;
      sram_oe = 1'b1;
      sram_a  = bus.im_addr[ADDR_W+1:2];
    end else if (dm_gnt) begin
      sram_cs  = 1'b1;
      sram_oe  = dm_is_read;
      sram_a   = bus.dm_addr[ADDR_W+1:2];
      sram_web = ~bus.dm_we;
      sram_di  = bus.dm_wdata;
    end
  end

  // Owner of next cycle's read data; dm writes complete at the grant edge.
  always_comb begin
    owner_d = OWN_NONE;
    if (im_gnt)                    owner_d = OWN_IM;
    else if (dm_gnt && dm_is_read) owner_d = OWN_DM_RD;
  end

  // Owner register; reset discards any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) owner_q <= OWN_NONE;
    else      owner_q <= owner_d;
  end

  // Responses: the owner flop selects which port sees sram_do this cycle.
  assign bus.im_rvalid = (owner_q == OWN_IM);
  assign bus.dm_rvalid = (owner_q == OWN_DM_RD);
  assign bus.im_rdata  = bus.im_rvalid ? sram_do : 32'h0;
  assign bus.dm_rdata  = bus.dm_rvalid ? sram_do : 32'h0;

  // Byte-offset and above-range address bits are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.im_addr[31:ADDR_W+2], bus.im_addr[1:0],
                         bus.dm_addr[31:ADDR_W+2], bus.dm_addr[1:0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios followed by randomized
// requesters that honour the hold-until-grant rule, all checked every cycle
// against a behavioural model (arbitration rules, a word-array memory and a
// one-deep response slot per port). Also covers SRAM_ARB_RR_EN builds.
module tb_sram_port_arbiter;
  localparam int ADDR_W   = 14;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  logic              sram_cs, sram_oe;
  logic [ADDR_W-1:0] sram_a;
  logic [3:0]        sram_web;
  logic [31:0]       sram_di, sram_do;

  sram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sram_cs (sram_cs),
    .sram_oe (sram_oe),
    .sram_a  (sram_a),
    .sram_web(sram_web),
    .sram_di (sram_di),
    .sram_do (sram_do)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Behavioural single-port SRAM: byte writes and 1-cycle read latency.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        for (int b = 0; b < 4; b++)
          if (!sram_web[b]) mem[sram_a][8*b +: 8] = sram_di[8*b +: 8];
        if (sram_oe) sram_do <= mem[sram_a];
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [DEPTH];
  int          wcnt;          // consecutive denied im cycles
  bit          last_im;       // last winner was im (round-robin build)
  bit          pend_im, pend_dm;
  logic [31:0] pend_im_data, pend_dm_data;
  int          n_cmp, n_bad;
  int          gnt_im_seen;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt    = 0;
    last_im = 1'b1;
    pend_im = 1'b0;
    pend_dm = 1'b0;
    pend_im_data = '0;
    pend_dm_data = '0;
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) & 32'(DEPTH - 1));
  endfunction

  // One clock cycle: drive after negedge, check, advance the model, pass posedge.
  task automatic cycle(input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [3:0] dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       output bit gi, output bit gd);
    logic        e_cs, e_oe;
    logic [31:0] e_a, e_web, e_di;
    int          iw, dw;
    @(negedge clk);
    bus.im_req   = ir;
    bus.im_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dwe;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
    #1;
    iw = word_of(ia);
    dw = word_of(da);
`ifdef SRAM_ARB_RR_EN
    if (ir && dr) begin
      gd = last_im;
      gi = !last_im;
    end else begin
      gi = ir;
      gd = dr;
    end
`else
    gi = ir && (wcnt == MAX_WAIT || !dr);
    gd = dr && !gi;
`endif
    e_cs = gi || gd; e_oe = 1'b0; e_a = '0; e_web = 32'hF; e_di = '0;
    if (gi) begin
      e_oe = 1'b1; e_a = 32'(iw);
    end else if (gd) begin
      e_oe = (dwe == 4'h0); e_a = 32'(dw); e_web = {28'h0, ~dwe}; e_di = dwd;
    end
    check("im_gnt", bus.im_gnt, gi);
    check("dm_gnt", bus.dm_gnt, gd);
    check("both_gnt", bus.im_gnt & bus.dm_gnt, 32'h0);
    check("sram_cs", sram_cs, e_cs);
    check("sram_oe", sram_oe, e_oe);
    check("sram_a", 32'(sram_a), e_a);
    check("sram_web", 32'(sram_web), e_web);
    check("sram_di", sram_di, e_di);
    check("im_rvalid", bus.im_rvalid, pend_im);
    check("dm_rvalid", bus.dm_rvalid, pend_dm);
    check("im_rdata", bus.im_rdata, pend_im ? pend_im_data : 32'h0);
    check("dm_rdata", bus.dm_rdata, pend_dm ? pend_dm_data : 32'h0);
    if (bus.im_gnt === 1'b1) gnt_im_seen++;

    // Advance the model to the state after this edge.
    pend_im      = gi;
    pend_im_data = gi ? ref_mem[iw] : 32'h0;
    pend_dm      = gd && (dwe == 4'h0);
    pend_dm_data = pend_dm ? ref_mem[dw] : 32'h0;
    if (gd && dwe != 4'h0)
      for (int b = 0; b < 4; b++)
        if (dwe[b]) ref_mem[dw][8*b +: 8] = dwd[8*b +: 8];
    if (ir && !gi) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
    else           wcnt = 0;
    if (gi)      last_im = 1'b1;
    else if (gd) last_im = 1'b0;
    @(posedge clk);
  endtask

  task automatic idle();
    bit g1, g2;
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g1, g2);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi;
    hi = $urandom & ~(32'(DEPTH - 1) << 2);
    return hi | (32'($urandom_range(63)) << 2);
  endfunction

  initial begin
    bit          g1, g2, ip, dp;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe;
    n_cmp = 0; n_bad = 0; gnt_im_seen = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst = 1'b0;
    bus.im_req = 1'b0; bus.im_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = '0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_im_rvalid", bus.im_rvalid, 32'h0);
    check("rst_dm_rvalid", bus.dm_rvalid, 32'h0);
    check("rst_sram_cs", sram_cs, 32'h0);
    rst = 1'b1;

    // Instruction fetch alone, three back-to-back grants of word 4.
    repeat (3) cycle(1'b1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 32'h0, g1, g2);
    idle();

    // Half-word write then read-back of the same word.
    cycle(1'b0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'hDEAD_BEEF, g1, g2);
    cycle(1'b0, 32'h0, 1'b1, 4'b0000, 32'h20, 32'h0, g1, g2);
    idle();

    // Full-word write with im idle: no response follows.
    cycle(1'b0, 32'h0, 1'b1, 4'hF, 32'h44, 32'h1234_5678, g1, g2);
    idle();

    // Both ports held high: dm x MAX_WAIT then im (or strict alternation).
    gnt_im_seen = 0;
    repeat (20) cycle(1'b1, 32'h30, 1'b1, 4'h0, 32'h40, 32'h0, g1, g2);
`ifdef SRAM_ARB_RR_EN
    check("hold_im_grants", 32'(gnt_im_seen), 32'd10);
`else
    check("hold_im_grants", 32'(gnt_im_seen), 32'(20 / (MAX_WAIT + 1)));
`endif

    // Reset asserted while a read is in flight, for each port.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) cycle(1'b1, 32'h14, 1'b0, 4'h0, 32'h0, 32'h0, g1, g2);
      else        cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h24, 32'h0, g1, g2);
      #2;
      rst = 1'b0;
      bus.im_req = 1'b0;
      bus.dm_req = 1'b0;
      #1;
      check("midrst_im_rvalid", bus.im_rvalid, 32'h0);
      check("midrst_dm_rvalid", bus.dm_rvalid, 32'h0);
      model_reset();
      #1;
      rst = 1'b1;
      idle();
    end

    // Randomized requesters obeying hold-until-grant.
    ip = 1'b0; dp = 1'b0;
    ia = '0; da = '0; dwd = '0; dwe = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(3) != 0) begin
        ip = 1'b1;
        ia = rand_addr();
      end
      if (!dp && $urandom_range(2) != 0) begin
        dp  = 1'b1;
        da  = rand_addr();
        dwe = ($urandom_range(1) != 0) ? 4'($urandom) : 4'h0;
        dwd = $urandom;
      end
      cycle(ip, ia, dp, dwe, da, dwd, g1, g2);
      if (g1) ip = 1'b0;
      if (g2) dp = 1'b0;
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port SRAM_wrapper instance between the CPU instruction-fetch port and the data port, for a unified-memory configuration of top.
- Per-cycle arbitration: one access per cycle.
- Data port has fixed priority. A starvation counter forces instruction-fetch grants.
- Read data returns one cycle after grant, matching the SRAM's 1-cycle read latency.

Parameters:
- ADDR_W, 14, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- MAX_WAIT, 4, consecutive denied im cycles before im is force-granted (1..15).
- CNT_W, 4, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- im_req  in  1  instruction read request; held with im_addr until im_gnt.
- im_addr  in  32  instruction byte address.
- im_gnt  out  1  combinational grant for im in the current cycle.
- im_rvalid  out  1  registered; im_rdata valid this cycle.
- im_rdata  out  32  instruction read data.
- dm_req  in  1  data request; held with dm_* until dm_gnt.
- dm_we  in  4  active-high byte write enables; 4'h0 means read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  write data.
- dm_gnt  out  1  combinational grant for dm.
- dm_rvalid  out  1  registered; dm_rdata valid (reads only).
- dm_rdata  out  32  data read data.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_a  out  ADDR_W  SRAM word address.
- sram_web  out  4  SRAM active-low byte write enables.
- sram_di  out  32  SRAM write data.
- sram_do  in  32  SRAM read data (valid the cycle after the read is issued).

Behaviour:
- Reset (rst=0, asynchronous):
  - im_rvalid=0, dm_rvalid=0, starvation counter=0, owner register=NONE.
  - Any in-flight read is discarded; no rvalid is produced for it after reset release.
- Grant logic, combinational, one winner per cycle:
  - force = im_req && (wait_cnt == MAX_WAIT).
  - If force: im_gnt=1, dm_gnt=0.
  - Else if dm_req: dm_gnt=1.
  - Else if im_req: im_gnt=1.
  - Never both asserted.
- SRAM drive:
  - im granted: cs=1, oe=1, a=im_addr[ADDR_W+1:2], web=4'hF, di=0.
  - dm granted: cs=1, a=dm_addr[ADDR_W+1:2], web=~dm_we, di=dm_wdata. oe=1 only when dm_we==0.
  - No grant: cs=0, oe=0, web=4'hF, a=0, di=0.
  - Address bits [1:0] are ignored; no misalignment check.
- Owner register, next state:
  - IM if im granted.
  - DM_RD if dm granted with dm_we==0.
  - NONE otherwise, including dm writes.
- Responses:
  - im_rvalid = (owner==IM); dm_rvalid = (owner==DM_RD); both registered.
  - im_rdata = sram_do when im_rvalid, else 0. dm_rdata = sram_do when dm_rvalid, else 0.
  - Read latency is exactly 1 cycle after gnt. Back-to-back grants give 1 response per cycle.
  - Responses have no backpressure.
  - Writes produce no response; the write completes at the grant edge.
- Starvation counter:
  - Increments on cycles with im_req && !im_gnt, saturating at MAX_WAIT.
  - Clears on im_gnt or when im_req=0.
- Simultaneous req, counter below MAX_WAIT: dm wins.
- Requester changing addr/we while req=1 and gnt=0: not supported. Hold is the requester's obligation.
- Read-after-write to the same word on consecutive grants returns the new data (SRAM semantics).

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined:
  - Round-robin replaces fixed priority.
  - A last_winner flop (reset = IM) gives the other requester priority on a simultaneous request.
  - Starvation counter and MAX_WAIT logic are removed; wait_cnt is tied to 0.
- Undefined: fixed dm priority with the starvation counter, as above.

Test Plan:
- Only im_req=1, im_addr=0x0000_0010, 3 cycles -> im_gnt=1 each cycle; sram_a=0x4, oe=1, web=F; im_rvalid=1 one cycle later with im_rdata=preloaded word[4].
- dm_req=1, dm_we=4'b0011, addr=0x20, wdata=0xDEADBEEF; then dm read of 0x20 -> sram_web=4'b1100 on the write; dm_rvalid next cycle after the read; dm_rdata low half=0xBEEF, upper half unchanged.
- im_req and dm_req held high continuously, MAX_WAIT=4 -> grant pattern dm,dm,dm,dm,im repeating. Never both grants high. Counter returns to 0 after the im grant.
- dm write with dm_we=4'hF and im_req idle -> dm_gnt=1, sram_oe=0; no dm_rvalid; owner=NONE.
- Read granted, rst driven low mid-cycle before the next edge -> im_rvalid/dm_rvalid go 0 immediately. After release with no requests: no rvalid, sram_cs=0.
- With SRAM_ARB_RR_EN, both requests held -> strictly alternating grants starting with dm (last_winner=IM after reset).
